// File: rtl/br_predict_btb.sv
// br_predict_btb: direct-mapped branch target buffer with per-entry 2-bit
// saturating direction counters.
//
// Fetch gets a combinational hit/taken/target prediction for lookup_pc.
// Execute writes resolved outcomes through a single update port. Entries
// are allocated only by taken branches on a miss.
//
// Compile-time option: define BR_PREDICT_BYPASS_EN to forward a same-cycle
// update to a lookup of the same word address. Without it, lookup always
// reads registered state.
module br_predict_btb #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        flush,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    // Table state: valid and counter are control (reset), tag and target are data
    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    // Update-side decode
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;

    // Next contents of the entry addressed by upd_pc
    logic             valid_d;
    logic [1:0]       ctr_d;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      tgt_d;
    logic             wr_d;

    // Lookup-side decode and the entry the prediction is drawn from
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             src_valid;
    logic [1:0]       src_ctr;
    logic [TAG_W-1:0] src_tag;
    logic [31:0]      src_tgt;

    // The two byte-offset bits of each PC never address anything
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Counter step up, saturating at strong-taken
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // Counter step down, saturating at strong-not-taken
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];
    assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];

    // Compute the post-update entry; flush suppresses the update entirely
    always_comb begin
        valid_d = valid_q[upd_idx];
        ctr_d   = ctr_q[upd_idx];
        tag_d   = tag_q[upd_idx];
        tgt_d   = tgt_q[upd_idx];
        wr_d    = 1'b0;
        if (upd_en && !flush) begin
            if (upd_match) begin
                wr_d = 1'b1;
                if (upd_taken) begin
                    ctr_d = sat_inc(ctr_q[upd_idx]);
                    tgt_d = upd_target;
                end else begin
                    ctr_d = sat_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken) begin
                // Taken miss replaces whatever occupies the slot
                wr_d    = 1'b1;
                valid_d = 1'b1;
                tag_d   = upd_tag;
                tgt_d   = upd_target;
                ctr_d   = CTR_ALLOC;
            end
        end
    end

`ifdef BR_PREDICT_BYPASS_EN
    // Select the lookup source, forwarding the in-flight update on a word-address match
    always_comb begin
        src_valid = valid_q[lk_idx];
        src_ctr   = ctr_q[lk_idx];
        src_tag   = tag_q[lk_idx];
        src_tgt   = tgt_q[lk_idx];
        if (upd_en && !flush && (lookup_pc[31:2] == upd_pc[31:2])) begin
            src_valid = valid_d;
            src_ctr   = ctr_d;
            src_tag   = tag_d;
            src_tgt   = tgt_d;
        end
    end
`else
    // Select the lookup source: always the registered table
    always_comb begin
        src_valid = valid_q[lk_idx];
        src_ctr   = ctr_q[lk_idx];
        src_tag   = tag_q[lk_idx];
        src_tgt   = tgt_q[lk_idx];
    end
`endif

    // Form the prediction; target is forced to zero on a miss
    always_comb begin
        pred_hit    = src_valid && (src_tag == lk_tag);
        pred_taken  = pred_hit && src_ctr[1];
        pred_target = pred_hit ? src_tgt : 32'h0;
    end

    // Control state: async reset, flush clears valids, otherwise write the updated entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_d) begin
            valid_q[upd_idx] <= valid_d;
            ctr_q[upd_idx]   <= ctr_d;
        end
    end

    // Data state: tag and target only change on a write, never reset
    always_ff @(posedge CLK) begin
        if (wr_d) begin
            tag_q[upd_idx] <= tag_d;
            tgt_q[upd_idx] <= tgt_d;
        end
    end

endmodule

// File: tb/tb_br_predict_btb.sv
// tb_br_predict_btb: directed and randomized checks of br_predict_btb against
// an entry-level behavioural model. Honours BR_PREDICT_BYPASS_EN the same way
// the design does.
module tb_br_predict_btb;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        CLK;
    logic        nRST;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    br_predict_btb #(.ENTRIES(ENTRIES)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .flush      (flush),
        .lookup_pc  (lookup_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          v;
        int unsigned tag;
        int unsigned tgt;
        int          ctr;
    } ent_t;

    ent_t mdl [ENTRIES];

    int n_vec = 0;
    int n_err = 0;

    logic        obs_hit;
    logic        obs_taken;
    logic [31:0] obs_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    // Entry contents after a resolved branch at pc, from the direction/allocation rules
    function automatic ent_t next_ent(input ent_t e, input logic [31:0] pc,
                                      input bit tk, input logic [31:0] tgt);
        ent_t r = e;
        if (e.v && e.tag == tag_of(pc)) begin
            if (tk) begin
                r.ctr = (e.ctr + 1 > 3) ? 3 : e.ctr + 1;
                r.tgt = tgt;
            end else begin
                r.ctr = (e.ctr - 1 < 0) ? 0 : e.ctr - 1;
            end
        end else if (tk) begin
            r.v   = 1'b1;
            r.tag = tag_of(pc);
            r.tgt = tgt;
            r.ctr = 2;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            mdl[i].v   = 1'b0;
            mdl[i].ctr = 1;
            mdl[i].tag = 0;
            mdl[i].tgt = 0;
        end
    endtask

    // One cycle: drive at the falling edge, check settled outputs, advance the model
    task automatic step(input logic [31:0] lpc, input bit en, input logic [31:0] upc,
                        input bit tk, input logic [31:0] tgt, input bit fl, input string tag);
        ent_t        e;
        bit          eh;
        bit          et;
        logic [31:0] eg;
        @(negedge CLK);
        lookup_pc  = lpc;
        upd_en     = en;
        upd_pc     = upc;
        upd_taken  = tk;
        upd_target = tgt;
        flush      = fl;
        #1;
        e = mdl[idx_of(lpc)];
`ifdef BR_PREDICT_BYPASS_EN
        if (en && !fl && lpc[31:2] == upc[31:2])
            e = next_ent(mdl[idx_of(upc)], upc, tk, tgt);
`endif
        eh = e.v && (e.tag == tag_of(lpc));
        et = eh && (e.ctr >= 2);
        eg = eh ? e.tgt : 32'h0;
        check({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, eh});
        check({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, et});
        check({tag, ".target"}, pred_target,         eg);
        obs_hit   = pred_hit;
        obs_taken = pred_taken;
        obs_tgt   = pred_target;
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) mdl[i].v = 1'b0;
        end else if (en) begin
            mdl[idx_of(upc)] = next_ent(mdl[idx_of(upc)], upc, tk, tgt);
        end
    endtask

    task automatic look(input logic [31:0] lpc, input string tag);
        step(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic upd(input logic [31:0] upc, input bit tk, input logic [31:0] tgt);
        step(32'h0, 1'b1, upc, tk, tgt, 1'b0, "upd");
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] lpc;
        nRST       = 1'b0;
        flush      = 1'b0;
        lookup_pc  = 32'h40;
        upd_en     = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        model_reset();
        #2;
        check("rst.hit",    {31'd0, pred_hit},   32'd0);
        check("rst.taken",  {31'd0, pred_taken}, 32'd0);
        check("rst.target", pred_target,         32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Empty table lookup
        look(32'h40, "empty40");
        check("tp_empty.hit", {31'd0, obs_hit}, 32'd0);

        // Allocate then hit; aliasing tag misses
        upd(32'h40, 1'b1, 32'h100);
        look(32'h40, "alloc40");
        check("tp_alloc.hit",    {31'd0, obs_hit},   32'd1);
        check("tp_alloc.taken",  {31'd0, obs_taken}, 32'd1);
        check("tp_alloc.target", obs_tgt,            32'h100);
        look(32'h80, "alias80");
        check("tp_alias.hit", {31'd0, obs_hit}, 32'd0);

        // Counter walk down with saturation, then up with saturation
        for (int i = 0; i < 3; i++) begin
            upd(32'h40, 1'b0, 32'h0);
            look(32'h40, "dn");
        end
        check("tp_sat0.hit",   {31'd0, obs_hit},   32'd1);
        check("tp_sat0.taken", {31'd0, obs_taken}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            upd(32'h43, 1'b1, 32'h104);
            look(32'h41, "up");
        end
        check("tp_sat3.taken",  {31'd0, obs_taken}, 32'd1);
        check("tp_sat3.target", obs_tgt,            32'h104);
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40, "after_sat3");
        check("tp_sat3_dn.taken", {31'd0, obs_taken}, 32'd1);

        // Not-taken miss does not allocate
        upd(32'h200, 1'b0, 32'h300);
        look(32'h200, "nt200");
        check("tp_noalloc.hit", {31'd0, obs_hit}, 32'd0);

        // Flush wins over a same-cycle update
        upd(32'h40, 1'b1, 32'h100);
        step(32'h0, 1'b1, 32'h44, 1'b1, 32'h144, 1'b1, "flush");
        look(32'h40, "fl40");
        check("tp_flush40.hit", {31'd0, obs_hit}, 32'd0);
        look(32'h44, "fl44");
        check("tp_flush44.hit", {31'd0, obs_hit}, 32'd0);

        // Same-cycle update and lookup on an empty table
        do_reset();
        step(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, "same");
`ifdef BR_PREDICT_BYPASS_EN
        check("tp_same.hit",    {31'd0, obs_hit}, 32'd1);
        check("tp_same.target", obs_tgt,          32'h100);
`else
        check("tp_same.hit",    {31'd0, obs_hit}, 32'd0);
        check("tp_same.target", obs_tgt,          32'h0);
`endif
        look(32'h40, "same_next");

        // Randomized traffic over a small PC space so tags collide and entries hit
        for (int n = 0; n < 600; n++) begin
            rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0)
                lpc = rpc ^ $urandom_range(0, 3);
            else
                lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            step(lpc, $urandom_range(0, 3) != 0, rpc, $urandom_range(0, 1) == 1,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 29) == 0, "rnd");
        end

        // Asynchronous reset while a lookup is hitting
        upd(32'h48, 1'b1, 32'h248);
        look(32'h48, "pre_arst");
        check("arst_pre.hit", {31'd0, obs_hit}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        check("arst.hit",    {31'd0, pred_hit},   32'd0);
        check("arst.taken",  {31'd0, pred_taken}, 32'd0);
        check("arst.target", pred_target,         32'd0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        look(32'h48, "post_arst");
        check("arst_post.hit", {31'd0, obs_hit}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
